sa_result_reader: RTL and testbench

Readout engine on the far side of the systolic array: once the controller has loaded the operand registers and let the matmul run, this block walks the array's result registers through `REG_SELECT`. For each register it waits for the array's output to settle, captures the value, and streams it to the host side over a valid/ready interface, tagged with its index. It sits between `SystolicArray` and the host/controller. It drives the array's `REG_SELECT` input; the controller drives the load path (`WRITE`/`IDX`/`DIN_*`).

---
 rtl/sa_result_reader.sv | 111 +++++++++++
 tb/tb_sa_result_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_reader.sv
// Result readout engine for the systolic array.
// Steps REG_SELECT through the array's result registers. Each register is
// held for SETTLE_CYCLES edges before RES_DIN is captured. The captured word
// is then offered to the host over a valid/ready port, tagged with its index.
module sa_result_reader #(
  parameter int DATA_W        = 16,
  parameter int NUM_REGS      = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [DATA_W-1:0] RES_DIN,
  output logic [3:0]        REG_SELECT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [3:0]        OUT_IDX,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  // Index of the final register in a sweep, and the counter value on which
  // RES_DIN has been stable for SETTLE_CYCLES edges.
  localparam logic [3:0] LAST_IDX    = 4'(NUM_REGS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] idx;

  // BUSY is decoded from the state register alone, so it has no path from
  // any input.
  assign BUSY = (state != ST_IDLE);

  // Sweep sequencer: settle, capture, handshake, advance.
  // NOTE: every register here uses non-blocking assignment. Each branch then
  // sees the pre-edge values of state, cnt and idx, which matches the
  // hardware.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      REG_SELECT <= '0;
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
      OUT_IDX    <= '0;
      OUT_LAST   <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (ABORT && state != ST_IDLE) begin
        // An abort wins over a handshake on the same edge. That word is
        // treated as not delivered and no DONE pulse is produced.
        state      <= ST_IDLE;
        OUT_VALID  <= 1'b0;
        OUT_LAST   <= 1'b0;
        REG_SELECT <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (START) begin
              state      <= ST_SETTLE;
              idx        <= '0;
              REG_SELECT <= '0;
              cnt        <= '0;
            end
          end
          ST_SETTLE: begin
            cnt <= cnt + 4'd1;
            if (cnt == SETTLE_LAST) begin
              OUT_DATA  <= RES_DIN;
              OUT_IDX   <= idx;
              OUT_LAST  <= (idx == LAST_IDX);
              OUT_VALID <= 1'b1;
              state     <= ST_SEND;
            end
          end
          ST_SEND: begin
            // OUT_VALID is always high in this state. OUT_READY alone
            // therefore completes the handshake. While it stays low, every
            // output and REG_SELECT holds its value.
            if (OUT_READY) begin
              OUT_VALID <= 1'b0;
              if (OUT_LAST) begin
                OUT_LAST   <= 1'b0;
                REG_SELECT <= '0;
                DONE       <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                idx        <= idx + 4'd1;
                REG_SELECT <= idx + 4'd1;
                cnt        <= '0;
                state      <= ST_SETTLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_result_reader.sv
// Self-checking bench for sa_result_reader.
// Four readers are instantiated with different SETTLE_CYCLES and NUM_REGS
// values. One reader is exercised at a time: START and ABORT go only to the
// selected instance, and its outputs are muxed onto m_* for checking.
// Each instance has an array model that updates RES_DIN only S-1 cycles after
// its REG_SELECT changes. A capture taken too early therefore returns the
// previous register's word.
module tb_sa_result_reader;

  function automatic int s_of(input int i);
    case (i)
      1:       return 1;
      2:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int n_of(input int i);
    return (i == 3) ? 4 : 16;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        ready;
  logic [15:0] base;
  int          sel;
  int          cyc = 0;

  int errors = 0;
  int checks = 0;

  logic [3:0]  o_rsel  [4];
  logic        o_valid [4];
  logic [15:0] o_data  [4];
  logic [3:0]  o_idx   [4];
  logic        o_last  [4];
  logic        o_busy  [4];
  logic        o_done  [4];

  logic [3:0]  m_rsel;
  logic        m_valid;
  logic [15:0] m_data;
  logic [3:0]  m_idx;
  logic        m_last;
  logic        m_busy;
  logic        m_done;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [3:0]  pipe [4];
    logic [15:0] res;

    // Array model: RES_DIN follows REG_SELECT after S-1 cycles.
    always @(posedge clk) begin
      pipe[0] <= o_rsel[g];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end

    if (s_of(g) == 1) begin : g_comb
      assign res = base + {12'd0, o_rsel[g]};
    end else begin : g_dly
      assign res = base + {12'd0, pipe[s_of(g)-2]};
    end

    sa_result_reader #(
      .DATA_W       (16),
      .NUM_REGS     (n_of(g)),
      .SETTLE_CYCLES(s_of(g))
    ) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .START     (start && (sel == g)),
      .ABORT     (abort && (sel == g)),
      .RES_DIN   (res),
      .REG_SELECT(o_rsel[g]),
      .OUT_VALID (o_valid[g]),
      .OUT_READY (ready),
      .OUT_DATA  (o_data[g]),
      .OUT_IDX   (o_idx[g]),
      .OUT_LAST  (o_last[g]),
      .BUSY      (o_busy[g]),
      .DONE      (o_done[g])
    );
  end

  always_comb begin
    m_rsel  = o_rsel[sel];
    m_valid = o_valid[sel];
    m_data  = o_data[sel];
    m_idx   = o_idx[sel];
    m_last  = o_last[sel];
    m_busy  = o_busy[sel];
    m_done  = o_done[sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_last"},  m_last,  0);
    check({tag, "_rsel"},  m_rsel,  0);
    check({tag, "_busy"},  m_busy,  0);
  endtask

  // Runs n_sweeps sweeps on instance inst and checks them against a
  // transaction model. The model expects word k to be (b+k) with index k.
  // After a handshake at edge H, REG_SELECT is k+1 and the next OUT_VALID
  // appears after edge H+S. The task must be called at a negedge, and it
  // returns at a negedge.
  task automatic sweep(input int inst, input logic [15:0] b, input int n_sweeps,
                       input int ready_pct, input int abort_word,
                       input int rst_word, input bit hold_start);
    int s, n, e_start, nve, k, guard, hs;
    bit fin;
    s     = s_of(inst);
    n     = n_of(inst);
    sel   = inst;
    base  = b;
    start = 1'b1;
    e_start = cyc + 1;
    for (int sw = 0; sw < n_sweeps; sw++) begin
      k     = 0;
      nve   = e_start + s;
      fin   = 1'b0;
      guard = 0;
      while (!fin) begin
        @(negedge clk);
        guard++;
        if (guard > 4000) begin
          check("sweep_timeout", 0, 1);
          start = 1'b0;
          return;
        end
        if (!hold_start) start = 1'b0;
        ready = ($urandom_range(99) < ready_pct);
        check("busy", m_busy, 1);
        check("done_mid", m_done, 0);
        check("rsel", m_rsel, k);
        if (cyc < nve) begin
          check("valid_low", m_valid, 0);
        end else begin
          check("valid", m_valid, 1);
          check("data", m_data, 16'(b + 16'(k)));
          check("idx", m_idx, k);
          check("last", m_last, (k == n - 1));
          if (k == rst_word) begin
            #2 rst_n = 1'b0;
            #1;
            check_idle_outputs("rst");
            check("rst_done", m_done, 0);
            check("rst_data", m_data, 0);
            check("rst_idx", m_idx, 0);
            start = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
          end
          if (k == abort_word) begin
            ready = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            check_idle_outputs("abort");
            check("abort_done", m_done, 0);
            @(negedge clk);
            check("abort_done2", m_done, 0);
            check("abort_busy2", m_busy, 0);
            return;
          end
          if (ready) begin
            if (k == n - 1) begin
              hs = cyc + 1;
              if (ready_pct == 100) check("last_hs_edge", hs - e_start, n * (s + 1));
              if (!(hold_start && sw < n_sweeps - 1)) start = 1'b0;
              @(negedge clk);
              check("done", m_done, 1);
              check_idle_outputs("done");
              fin = 1'b1;
              e_start = hs + 1;
              if (sw == n_sweeps - 1) begin
                @(negedge clk);
                check("done_pulse", m_done, 0);
                check("idle_busy", m_busy, 0);
              end
            end else begin
              k++;
              nve = cyc + 1 + s;
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    sel   = 0;
    base  = 16'h0100;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_done", m_done, 0);
    check("reset_data", m_data, 0);
    check("reset_idx", m_idx, 0);
    rst_n = 1'b1;
    while (cyc < 9) @(negedge clk);

    // Basic sweep: START sampled at edge 10, last handshake at edge 58.
    sweep(0, 16'h0100, 1, 100, -1, -1, 1'b0);
    // Backpressure with random data bases.
    sweep(0, 16'($urandom), 1, 30, -1, -1, 1'b0);
    sweep(0, 16'hFFF8, 1, 30, -1, -1, 1'b0);
    // Settle checks with SETTLE_CYCLES = 1 and 5.
    sweep(1, 16'($urandom), 1, 100, -1, -1, 1'b0);
    sweep(1, 16'($urandom), 1, 40, -1, -1, 1'b0);
    sweep(2, 16'($urandom), 1, 100, -1, -1, 1'b0);
    sweep(2, 16'($urandom), 1, 50, -1, -1, 1'b0);
    // Abort on the word-7 handshake, followed by a clean sweep.
    sweep(0, 16'h0100, 1, 100, 7, -1, 1'b0);
    sweep(0, 16'h0100, 1, 100, -1, -1, 1'b0);
    // Reset mid-SEND at word 4, followed by a clean sweep.
    sweep(0, 16'($urandom), 1, 60, -1, 4, 1'b0);
    sweep(0, 16'h0100, 1, 100, -1, -1, 1'b0);
    // Back-to-back sweeps with START held high.
    sweep(3, 16'($urandom), 3, 100, -1, -1, 1'b1);
    sweep(0, 16'($urandom), 2, 50, -1, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
